// File: rtl/wb_master_arbiter.sv
// Two-master, one-slave Wishbone B3 classic arbiter with fixed m0 priority,
// whole-cyc ownership and a watchdog that aborts accesses the slave never answers.
module wb_master_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, ABORT} state_t;

  localparam bit          WDOG_EN = (TIMEOUT != 0);
  localparam logic [15:0] LIMIT   = WDOG_EN ? 16'(TIMEOUT - 1) : 16'h0000;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;  // last granted master, names the victim of an abort
  logic [15:0] cnt_q, cnt_d;
  logic        stall;

  // Read data is never gated; only ack/err identify the addressed master.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  always_comb begin
    // NOTE: every output and next-state value gets a default before the case,
    // so no path through the block leaves a variable unassigned (no latches).
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = '0;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_sel_o   = '0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    grant_o   = 2'b00;
    timeout_o = 1'b0;
    stall     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (m0_cyc_i) begin
          state_d = GRANT0;
          owner_d = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = GRANT1;
          owner_d = 1'b1;
        end
      end
      GRANT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i;
        grant_o  = 2'b01;
      end
      GRANT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i;
        grant_o  = 2'b10;
      end
      ABORT: begin
        timeout_o = 1'b1;
        m0_err_o  = ~owner_q;
        m1_err_o  = owner_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Shared release and watchdog handling for both grant states; an ack or
    // err in the limit cycle wins over the abort.
    if (state_q == GRANT0 || state_q == GRANT1) begin
      stall = s_stb_o & ~s_ack_i & ~s_err_i;
      if (!s_cyc_o) begin
        state_d = IDLE;
      end else if (WDOG_EN && stall && cnt_q == LIMIT) begin
        state_d = ABORT;
      end else if (stall) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Scoreboard bench for wb_master_arbiter: directed master/slave sequences push
// expected ack/err/timeout events, a negedge monitor pops and compares them.
module tb_wb_master_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we;
  logic [3:0]  m0_sel;
  logic [31:0] m0_adr, m0_wdat;
  logic [31:0] m0_rdat;
  logic        m0_ack, m0_err;
  logic        m1_cyc, m1_stb, m1_we;
  logic [3:0]  m1_sel;
  logic [31:0] m1_adr, m1_wdat;
  logic [31:0] m1_rdat;
  logic        m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic        s_ack, s_err;
  logic [1:0]  grant;
  logic        timeout;

  // Second instance with the watchdog disabled, driven only by nt_cyc.
  logic        nt_cyc;
  logic [31:0] nt_m0_dat, nt_m1_dat, nt_s_adr, nt_s_dat;
  logic        nt_m0_ack, nt_m0_err, nt_m1_ack, nt_m1_err;
  logic        nt_s_cyc, nt_s_stb, nt_s_we;
  logic [3:0]  nt_s_sel;
  logic [1:0]  nt_grant;
  logic        nt_timeout;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [4:0]  ev;   // {timeout, m1_err, m1_ack, m0_err, m0_ack}
    logic [31:0] dat;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  wb_master_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_dat_o(m0_rdat),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_dat_o(m1_rdat),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wdat),
    .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err),
    .grant_o(grant), .timeout_o(timeout)
  );

  wb_master_arbiter #(.TIMEOUT(0)) dut_nt (
    .clk(clk), .rst(rst),
    .m0_cyc_i(nt_cyc), .m0_stb_i(nt_cyc), .m0_we_i(1'b0), .m0_sel_i(4'h0),
    .m0_adr_i(32'h0), .m0_dat_i(32'h0), .m0_dat_o(nt_m0_dat),
    .m0_ack_o(nt_m0_ack), .m0_err_o(nt_m0_err),
    .m1_cyc_i(1'b0), .m1_stb_i(1'b0), .m1_we_i(1'b0), .m1_sel_i(4'h0),
    .m1_adr_i(32'h0), .m1_dat_i(32'h0), .m1_dat_o(nt_m1_dat),
    .m1_ack_o(nt_m1_ack), .m1_err_o(nt_m1_err),
    .s_cyc_o(nt_s_cyc), .s_stb_o(nt_s_stb), .s_we_o(nt_s_we), .s_sel_o(nt_s_sel),
    .s_adr_o(nt_s_adr), .s_dat_o(nt_s_dat),
    .s_dat_i(32'h0), .s_ack_i(1'b0), .s_err_i(1'b0),
    .grant_o(nt_grant), .timeout_o(nt_timeout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic push(input logic [4:0] ev, input logic [31:0] dat);
    exp_t e;
    e.ev  = ev;
    e.dat = dat;
    exp_q.push_back(e);
  endtask

  // Monitor: any ack/err/timeout seen on the DUT must match the next expected event.
  always @(negedge clk) begin
    logic [4:0] ev;
    exp_t e;
    ev = {timeout, m1_err, m1_ack, m0_err, m0_ack};
    if (!rst && ev != 5'b0) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: got %b expected none", ev);
      end else begin
        e = exp_q.pop_front();
        if (ev !== e.ev) begin
          fails++;
          $display("FAIL event: got %b expected %b", ev, e.ev);
        end else if (ev[0] && m0_rdat !== e.dat) begin
          fails++;
          $display("FAIL m0_dat: got %h expected %h", m0_rdat, e.dat);
        end else if (ev[2] && m1_rdat !== e.dat) begin
          fails++;
          $display("FAIL m1_dat: got %h expected %h", m1_rdat, e.dat);
        end
      end
    end
  end

  initial begin
    logic nt_seen;
    rst = 1'b1;
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 4'hF; m0_adr = 32'h0; m0_wdat = 32'h0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 4'hF; m1_adr = 32'h0; m1_wdat = 32'h0;
    s_ack = 0; s_err = 0; s_rdat = 32'h0; nt_cyc = 0;
    repeat (3) step();
    rst = 1'b0;
    mid();
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_s_cyc", 32'(s_cyc), 32'h0);
    check("reset_timeout", 32'(timeout), 32'h0);

    // m1 single read, slave acks two cycles after the request
    step(); m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_0100; mid();
    check("m1_req_idle_grant", 32'(grant), 32'h0);
    step(); mid();
    check("m1_grant", 32'(grant), 32'h2);
    check("m1_s_adr", s_adr, 32'h0000_0100);
    check("m1_s_cyc", 32'(s_cyc), 32'h1);
    step(); s_ack = 1; s_rdat = 32'h2402_0005; push(5'b00100, 32'h2402_0005); mid();
    check("m1_read_m0_ack", 32'(m0_ack), 32'h0);
    step(); s_ack = 0; m1_cyc = 0; m1_stb = 0; mid();
    check("m1_release_s_cyc", 32'(s_cyc), 32'h0);
    step(); mid();
    check("m1_after_idle", 32'(grant), 32'h0);

    // simultaneous requests: m0 wins, m1 follows after one IDLE cycle
    step(); m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; mid();
    step(); s_ack = 1; s_rdat = 32'h1111_1111; push(5'b00001, 32'h1111_1111); mid();
    check("sim_m0_first", 32'(grant), 32'h1);
    step(); s_ack = 0; m0_cyc = 0; m0_stb = 0; mid();
    check("sim_m0_drop_grant", 32'(grant), 32'h1);
    step(); mid();
    check("sim_turnaround", 32'(grant), 32'h0);
    step(); s_ack = 1; s_rdat = 32'h2222_2222; push(5'b00100, 32'h2222_2222); mid();
    check("sim_m1_second", 32'(grant), 32'h2);
    step(); s_ack = 0; m1_cyc = 0; m1_stb = 0; mid();
    step(); mid();

    // m1 4-beat zero-wait burst, m0 requests at beat 2
    step(); m1_cyc = 1; m1_stb = 1; mid();
    for (int b = 0; b < 4; b++) begin
      step();
      s_ack = 1; s_rdat = 32'hB000_0000 + 32'(b);
      push(5'b00100, 32'hB000_0000 + 32'(b));
      if (b == 1) begin m0_cyc = 1; m0_stb = 1; end
      mid();
      check($sformatf("burst_beat%0d_grant", b), 32'(grant), 32'h2);
    end
    step(); s_ack = 0; m1_cyc = 0; m1_stb = 0; mid();
    check("burst_release_grant", 32'(grant), 32'h2);
    step(); mid();
    check("burst_turnaround", 32'(grant), 32'h0);
    step(); s_ack = 1; s_rdat = 32'h0000_00C0; push(5'b00001, 32'h0000_00C0); mid();
    check("burst_m0_granted", 32'(grant), 32'h1);
    step(); s_ack = 0; m0_cyc = 0; m0_stb = 0; mid();
    step(); mid();

    // TIMEOUT=4, slave silent: four wait cycles then ABORT
    step(); m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0BAD; mid();
    for (int i = 0; i < 4; i++) begin
      step(); mid();
      check($sformatf("to_wait%0d_stb", i), 32'(s_stb), 32'h1);
      check($sformatf("to_wait%0d_grant", i), 32'(grant), 32'h1);
    end
    step(); push(5'b10010, 32'h0); m0_cyc = 0; m0_stb = 0; mid();
    check("abort_s_cyc", 32'(s_cyc), 32'h0);
    check("abort_timeout", 32'(timeout), 32'h1);
    check("abort_grant", 32'(grant), 32'h0);
    step(); mid();
    check("abort_then_idle", 32'(grant), 32'h0);
    check("abort_pulse_once", 32'(timeout), 32'h0);

    // ack on the 4th wait cycle beats the watchdog; err passes through
    step(); m0_cyc = 1; m0_stb = 1; mid();
    repeat (3) begin step(); mid(); end
    step(); s_ack = 1; s_rdat = 32'hACED_0004; push(5'b00001, 32'hACED_0004); mid();
    check("late_ack_no_timeout", 32'(timeout), 32'h0);
    step(); s_ack = 0; s_err = 1; push(5'b00010, 32'h0); mid();
    check("err_still_granted", 32'(grant), 32'h1);
    step(); s_err = 0; m0_cyc = 0; m0_stb = 0; mid();
    step(); mid();
    check("err_then_idle", 32'(grant), 32'h0);

    // rst mid-grant drops the slave cycle; a stray ack goes nowhere
    step(); m1_cyc = 1; m1_stb = 1; mid();
    step(); mid();
    check("rst_pre_grant", 32'(grant), 32'h2);
    step(); rst = 1; mid();
    step(); rst = 0; m1_cyc = 0; m1_stb = 0; s_ack = 1; mid();
    check("rst_s_cyc", 32'(s_cyc), 32'h0);
    check("rst_grant", 32'(grant), 32'h0);
    step(); s_ack = 0; mid();

    // TIMEOUT=0: a silent slave never triggers an abort
    nt_seen = 1'b0;
    step(); nt_cyc = 1; mid();
    for (int i = 0; i < 20; i++) begin
      step(); mid();
      if (nt_timeout) nt_seen = 1'b1;
    end
    check("nt_still_granted", 32'(nt_grant), 32'h1);
    check("nt_no_timeout", 32'(nt_seen), 32'h0);
    step(); nt_cyc = 0; mid();

    step(); mid();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_master_arbiter.md
# wb_master_arbiter

Two-master, one-slave Wishbone B3 classic arbiter for the CPU's external bus. It shares one bus between the data-side Wishbone interface (MEM stage, master 0) and the instruction-side interface (IF stage, master 1). A granted master keeps the bus for its whole `cyc` period. A watchdog aborts any access whose slave never acknowledges, so the IF/MEM stall requests driven by the bus interfaces cannot hang the pipeline forever.

## Interface
- `TIMEOUT`, default 255: wait cycles without ack/err before an abort. Range 1..65535; 0 disables the watchdog.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i` in 1 each: data master cycle, strobe and write-enable.
- `m0_sel_i` in 4, `m0_adr_i` in 32, `m0_dat_i` in 32: data master byte selects, address and write data.
- `m0_dat_o` out 32, `m0_ack_o` out 1, `m0_err_o` out 1: data master read data, acknowledge and error.
- `m1_*`: instruction master, same set and widths as `m0_*`.
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1 each, `s_sel_o` out 4, `s_adr_o` out 32, `s_dat_o` out 32: slave-side request.
- `s_dat_i` in 32, `s_ack_i` in 1, `s_err_i` in 1: slave-side response.
- `grant_o` out 2: one-hot owner, bit0 = m0, bit1 = m1; 00 when idle or aborting.
- `timeout_o` out 1: one-cycle pulse in the ABORT cycle, for the exception logic.

## Operation
- States: IDLE, GRANT0, GRANT1, ABORT. State is registered. All outputs are combinational from the state and the inputs.
- IDLE
  - All `s_*` outputs are 0; all master ack/err outputs are 0.
  - If `m0_cyc_i` is high: go to GRANT0. Else if `m1_cyc_i` is high: go to GRANT1. m0 has fixed priority.
- GRANTx
  - `s_cyc_o`, `s_stb_o`, `s_we_o`, `s_sel_o`, `s_adr_o` and `s_dat_o` equal the corresponding `mx` inputs.
  - `mx_ack_o` = `s_ack_i` and `mx_err_o` = `s_err_i`. The other master's ack/err are 0.
- Both `m0_dat_o` and `m1_dat_o` always equal `s_dat_i`; only ack/err are gated.
- GRANTx to IDLE when `mx_cyc_i` is low. The slave sees `cyc` fall in the same cycle. IDLE always lasts at least one cycle, which is the bus turnaround.
- The other master's requests are ignored while GRANTx holds, with no preemption. Burst/locked sequences are therefore safe while `cyc` stays high.
- Watchdog counter (16-bit)
  - In GRANTx it increments when `s_stb_o` = 1 and `s_ack_i` = 0 and `s_err_i` = 0.
  - It clears on ack, on err, when `stb` is low, and in any non-GRANT state.
  - When the counter equals `TIMEOUT-1` and the current cycle has no ack/err: go to ABORT.
- ABORT, exactly one cycle
  - `s_cyc_o` = `s_stb_o` = 0.
  - The previous owner sees `mx_err_o` = 1.
  - `timeout_o` = 1, `grant_o` = 00.
  - Then go to IDLE. A master still holding `cyc` is re-arbitrated normally.

## Timing
- Reset values: state IDLE, counter 0. Every `s_*` output, every ack/err, `grant_o` and `timeout_o` are 0.
- Grant latency: `cyc` sampled high in IDLE at edge N gives the slave request in cycle N+1.
- Ack/err pass through combinationally with zero added latency. A zero-wait slave gives one transfer per cycle after the grant.
- Release: `cyc` low causes IDLE at the next edge. A pending master is granted one cycle later. Minimum gap between owners is 1 IDLE cycle.
- Ack and timeout in the same cycle: the ack wins and the counter clears.
- `s_err_i` during GRANT passes through as an error; the watchdog does not fire.
- `rst` mid-transfer: IDLE at the next edge. `s_cyc_o` drops, with no ack/err to either master.
- `TIMEOUT` = 0: the counter never triggers ABORT.

## Test plan
- m1 single read: `cyc`/`stb` up with `adr` = 0x00000100; the slave acks 2 cycles later with 0x24020005 -> `grant_o` = 10 one cycle after the request; `m1_ack_o` is high for one cycle; `m1_dat_o` = 0x24020005; `m0_ack_o` stays 0.
- Simultaneous requests in IDLE -> m0 granted first. m1 is granted exactly 2 cycles after m0 drops `cyc`, with one IDLE cycle between.
- m1 in a 4-beat zero-wait burst while m0 requests at beat 2 -> all 4 m1 acks complete, no preemption; m0 is granted after m1 releases.
- `TIMEOUT` = 4 with a slave that never acks -> `stb` is held 4 cycles. The 5th cycle is ABORT: `s_cyc_o` = 0, `mx_err_o` = 1, `timeout_o` = 1. The state is then IDLE.
- Ack arriving on the 4th wait cycle with `TIMEOUT` = 4 -> normal ack, no `timeout_o`. `rst` asserted mid-grant -> all outputs 0 at the next edge.
